// File: rtl/flash_loader.sv
// ---------------------------------------------------------------------------
// flash_loader
//
// Copies a block of 32-bit words from SPI flash (one byte per driver read)
// into RAM. Each word is assembled little-endian from four consecutive flash
// bytes, then written to RAM with a full byte mask.
//
// Optional feature:
//   FLASH_LOADER_CHECKSUM_EN  when defined, `checksum` is the mod-2^32 sum of
//                             every word accepted by RAM since the last
//                             accepted start. When undefined it is tied to 0.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               one-cycle launch pulse, honoured only in IDLE
//   src_addr            first flash byte address (FLASH_AW bits)
//   dst_addr            first RAM byte address (word aligned)
//   nwords              number of 32-bit words to copy
//   busy, done          copy in progress / one-cycle completion pulse
//   checksum            running word sum (see above)
//   flash_sel           select to the SPI flash driver
//   flash_wstrb         one-cycle read request to the flash driver
//   flash_wdata         {8'h00, flash byte address zero-extended to 24 bits}
//   flash_wbusy         driver busy; read byte not yet valid
//   flash_rdata         driver read data, only [7:0] is used
//   mem_addr            RAM write byte address
//   mem_wdata           RAM write data
//   mem_wmask           RAM byte mask (4'b1111 during a write)
//   mem_wstrb           RAM write request
//   mem_wbusy           RAM stall
//   dbg_state           current FSM state encoding, for observation only
//
// Handshakes:
//   RAM:   mem_wstrb is the request and stays high with stable mem_addr /
//          mem_wdata / mem_wmask; the write is taken in the first cycle with
//          mem_wstrb=1 and mem_wbusy=0.
//   Flash: flash_wstrb is issued only in a cycle with flash_wbusy=0. The
//          driver raises flash_wbusy the cycle after the strobe; the read
//          byte is valid once flash_wbusy falls again.
// ---------------------------------------------------------------------------
module flash_loader #(
  parameter int FLASH_AW = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [FLASH_AW-1:0] src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [15:0]         nwords,
  output logic                busy,
  output logic                done,
  output logic [31:0]         checksum,
  output logic                flash_sel,
  output logic                flash_wstrb,
  output logic [31:0]         flash_wdata,
  input  logic                flash_wbusy,
  input  logic [31:0]         flash_rdata,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wmask,
  output logic                mem_wstrb,
  input  logic                mem_wbusy,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_ARM     = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_WRITE   = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [FLASH_AW-1:0] faddr_q, faddr_d;
  logic [31:0]         maddr_q, maddr_d;
  logic [31:0]         word_q,  word_d;
  logic [15:0]         count_q, count_d;
  logic [1:0]          k_q,     k_d;
  logic                mem_accept;

  // Upper read-data bits carry nothing for a byte-wide flash read.
  logic unused_rdata;
  assign unused_rdata = ^flash_rdata[31:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      faddr_q <= '0;
      maddr_q <= '0;
      word_q  <= '0;
      count_q <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      faddr_q <= faddr_d;
      maddr_q <= maddr_d;
      word_q  <= word_d;
      count_q <= count_d;
      k_q     <= k_d;
    end
  end

  assign mem_accept = (state_q == S_WRITE) && !mem_wbusy;

  always_comb begin
    state_d     = state_q;
    faddr_d     = faddr_q;
    maddr_d     = maddr_q;
    word_d      = word_q;
    count_d     = count_q;
    k_d         = k_q;
    busy        = 1'b0;
    done        = 1'b0;
    flash_sel   = 1'b0;
    flash_wstrb = 1'b0;
    mem_wstrb   = 1'b0;
    mem_wmask   = 4'b0000;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (nwords != 16'd0) begin
            faddr_d = src_addr;
            maddr_d = dst_addr;
            count_d = nwords;
            k_d     = 2'd0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        busy = 1'b1;
        // Never strobe while the driver is still busy; this also lets a
        // read left over from an interrupted copy drain after reset.
        if (!flash_wbusy) begin
          flash_sel   = 1'b1;
          flash_wstrb = 1'b1;
          state_d     = S_ARM;
        end
      end
      S_ARM: begin
        // The driver's wbusy lags the strobe by one cycle; skip that cycle
        // so WAIT does not mistake a stale wbusy=0 for a finished read.
        busy      = 1'b1;
        flash_sel = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        busy      = 1'b1;
        flash_sel = 1'b1;
        if (!flash_wbusy) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy                     = 1'b1;
        flash_sel                = 1'b1;
        word_d[{k_q, 3'b000} +: 8] = flash_rdata[7:0];
        faddr_d                  = faddr_q + 1'b1;
        k_d                      = k_q + 2'd1;
        state_d                  = (k_q == 2'd3) ? S_WRITE : S_ISSUE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_wstrb = 1'b1;
        mem_wmask = 4'b1111;
        if (mem_accept) begin
          maddr_d = maddr_q + 32'd4;
          count_d = count_q - 16'd1;
          state_d = (count_q == 16'd1) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign flash_wdata = {8'h00, 24'(faddr_q)};
  assign mem_addr    = maddr_q;
  assign mem_wdata   = word_q;
  assign dbg_state   = state_q;

`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == S_IDLE && start) csum_d = '0;
    else if (mem_accept)            csum_d = csum_q + word_q;
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_flash_loader.sv
// ---------------------------------------------------------------------------
// tb_flash_loader
//
// Bench for flash_loader. A flash driver model answers each strobe with a
// byte from a fixed image after a programmable latency; a RAM model can
// stall writes. A transaction model predicts, from every accepted start,
// the ordered flash addresses, the RAM writes, busy, done and checksum, and
// one compare process checks the DUT against it every cycle. Directed tests
// add literal expectations for the known image.
// ---------------------------------------------------------------------------
module tb_flash_loader;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] nwords;
  logic        busy, done;
  logic [31:0] checksum;
  logic        flash_sel, flash_wstrb, flash_wbusy;
  logic [31:0] flash_wdata, flash_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wstrb, mem_wbusy;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  flash_loader #(.FLASH_AW(24)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .nwords(nwords),
    .busy(busy), .done(done), .checksum(checksum),
    .flash_sel(flash_sel), .flash_wstrb(flash_wstrb), .flash_wdata(flash_wdata),
    .flash_wbusy(flash_wbusy), .flash_rdata(flash_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wstrb(mem_wstrb), .mem_wbusy(mem_wbusy), .dbg_state(dbg_state)
  );

`ifdef FLASH_LOADER_CHECKSUM_EN
  localparam logic [31:0] CK_T1 = 32'hCCAA8866;
`else
  localparam logic [31:0] CK_T1 = 32'h0000_0000;
`endif

  // ---------------- counters / scoreboard state ----------------
  int n_vec = 0;
  int n_bad = 0;
  int flash_lat  = 2;
  int stall_left = 0;
  int waited     = 0;

  logic [23:0] fl_exp_q[$];
  logic [31:0] wa_exp_q[$];
  logic [31:0] wd_exp_q[$];
  logic [23:0] fl_log[$];
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];

  logic [31:0] exp_ck    = '0;
  logic        done_due  = 1'b0;
  logic        prev_rst  = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_ma   = '0;
  logic [31:0] prev_md   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flash image: 11,22,...,88 at 0x100000; elsewhere a fixed address hash.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    logic [23:0] off;
    off = a - 24'h100000;
    if (off < 24'd8) return 8'h11 * (8'(off) + 8'd1);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // ---------------- flash driver model ----------------
  initial begin : flash_drv
    logic [23:0] a;
    flash_wbusy = 1'b0;
    flash_rdata = '0;
    forever begin
      @(negedge clk);
      if (flash_wstrb === 1'b1) begin
        a = flash_wdata[23:0];
        @(posedge clk); #1;
        flash_wbusy = 1'b1;
        repeat (flash_lat) @(posedge clk);
        #1;
        flash_wbusy = 1'b0;
        flash_rdata = {24'hA5C3E1, fbyte(a)};
      end
    end
  end

  // ---------------- RAM stall model ----------------
  initial begin : mem_drv
    mem_wbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_wstrb === 1'b1 && stall_left > 0) begin
        mem_wbusy = 1'b1;
        stall_left--;
      end else begin
        mem_wbusy = 1'b0;
      end
    end
  end

  // ---------------- model + compare process ----------------
  initial begin : compare
    logic [31:0] ea, ed, wrd;
    logic [23:0] fa;
    forever begin
      @(negedge clk); #1;
      if (reset === 1'b1) begin
        fl_exp_q.delete(); wa_exp_q.delete(); wd_exp_q.delete();
        done_due  = 1'b0;
        exp_ck    = '0;
        prev_rst  = 1'b1;
        prev_hold = 1'b0;
      end else begin
        if (prev_rst) begin
          chk("reset_ctrl", {busy, done, flash_sel, flash_wstrb, mem_wstrb, mem_wmask}, 9'd0);
          chk("reset_data", 64'(flash_wdata | mem_addr | mem_wdata | checksum), 64'd0);
        end
        chk("checksum", checksum, exp_ck);
        chk("busy", busy, (fl_exp_q.size() != 0) || (wa_exp_q.size() != 0));
        chk("done", done, done_due);
        done_due = 1'b0;
        chk("wmask", mem_wmask, mem_wstrb ? 4'hF : 4'h0);
        if (!busy) chk("sel_idle", flash_sel, 1'b0);

        if (flash_wstrb) begin
          chk("strobe_sel", flash_sel, 1'b1);
          chk("strobe_wbusy", flash_wbusy, 1'b0);
          fl_log.push_back(flash_wdata[23:0]);
          chk("flash_count", fl_exp_q.size() != 0, 1'b1);
          if (fl_exp_q.size() != 0) begin
            fa = fl_exp_q.pop_front();
            chk("flash_addr", flash_wdata, {8'h00, fa});
          end
        end

        if (mem_wstrb) begin
          chk("write_sel", flash_sel, 1'b0);
          if (prev_hold) begin
            chk("hold_addr", mem_addr, prev_ma);
            chk("hold_data", mem_wdata, prev_md);
          end
          if (!mem_wbusy) begin
            wa_log.push_back(mem_addr);
            wd_log.push_back(mem_wdata);
            chk("write_count", wa_exp_q.size() != 0, 1'b1);
            if (wa_exp_q.size() != 0) begin
              ea = wa_exp_q.pop_front();
              ed = wd_exp_q.pop_front();
              chk("write_addr", mem_addr, ea);
              chk("write_data", mem_wdata, ed);
`ifdef FLASH_LOADER_CHECKSUM_EN
              exp_ck = exp_ck + ed;
`endif
              if (wa_exp_q.size() == 0) done_due = 1'b1;
            end
          end
        end
        prev_hold = mem_wstrb && mem_wbusy;
        prev_ma   = mem_addr;
        prev_md   = mem_wdata;

        // A start is honoured only when idle (neither busy nor finishing).
        if (start && !busy && !done) begin
          exp_ck = '0;
          if (nwords == 16'd0) begin
            done_due = 1'b1;
          end else begin
            for (int w = 0; w < int'(nwords); w++) begin
              wrd = '0;
              for (int j = 0; j < 4; j++) begin
                fa = src_addr + 24'(4 * w + j);
                fl_exp_q.push_back(fa);
                wrd[8*j +: 8] = fbyte(fa);
              end
              wa_exp_q.push_back(dst_addr + 32'(4 * w));
              wd_exp_q.push_back(wrd);
            end
          end
        end
        prev_rst = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_start(input logic [23:0] s, input logic [31:0] d, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; nwords = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    waited = 0;
    while (done !== 1'b1 && waited < limit) begin
      @(negedge clk); #2;
      waited++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic clear_logs();
    fl_log.delete(); wa_log.delete(); wd_log.delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin : main
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; nwords = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, 3'd0);
    chk("rst_maddr", mem_addr, 32'd0);

    // Known image copy: two words.
    clear_logs();
    do_start(24'h100000, 32'h1000, 16'd2);
    wait_done(500);
    cycles(2);
    chk("t1_nflash", fl_log.size(), 8);
    chk("t1_nwr", wa_log.size(), 2);
    if (fl_log.size() == 8) begin
      chk("t1_fl0", fl_log[0], 24'h100000);
      chk("t1_fl7", fl_log[7], 24'h100007);
    end
    if (wa_log.size() == 2) begin
      chk("t1_wa0", wa_log[0], 32'h1000);
      chk("t1_wd0", wd_log[0], 32'h44332211);
      chk("t1_wa1", wa_log[1], 32'h1004);
      chk("t1_wd1", wd_log[1], 32'h88776655);
    end
    chk("t1_checksum", checksum, CK_T1);

    // Zero-length copy: done quickly, no accesses.
    clear_logs();
    do_start(24'h100000, 32'h1800, 16'd0);
    wait_done(4);
    chk("t2_latency", waited <= 1, 1'b1);
    cycles(3);
    chk("t2_nflash", fl_log.size(), 0);
    chk("t2_nwr", wa_log.size(), 0);

    // RAM stall of 5 cycles on the first write.
    clear_logs();
    stall_left = 5;
    do_start(24'h100010, 32'h2000, 16'd3);
    wait_done(800);
    cycles(2);
    chk("t3_nwr", wa_log.size(), 3);
    chk("t3_stall_used", stall_left, 0);
    if (wa_log.size() == 3) chk("t3_wd0", wd_log[0], 32'h2F2E2D2C);

    // Flash and RAM address wrap.
    clear_logs();
    do_start(24'hFFFFFE, 32'hFFFFFFFC, 16'd2);
    wait_done(800);
    cycles(2);
    chk("t4_nflash", fl_log.size(), 8);
    if (fl_log.size() == 8) begin
      chk("t4_fl0", fl_log[0], 24'hFFFFFE);
      chk("t4_fl1", fl_log[1], 24'hFFFFFF);
      chk("t4_fl2", fl_log[2], 24'h000000);
      chk("t4_fl3", fl_log[3], 24'h000001);
    end
    if (wa_log.size() == 2) begin
      chk("t4_wa0", wa_log[0], 32'hFFFFFFFC);
      chk("t4_wa1", wa_log[1], 32'h00000000);
    end

    // Reset while waiting on a slow flash read, then restart.
    clear_logs();
    flash_lat = 8;
    do_start(24'h100000, 32'h3000, 16'd1);
    waited = 0;
    while (flash_wstrb !== 1'b1 && waited < 20) begin
      @(negedge clk); #2;
      waited++;
    end
    chk("t5_strobe", flash_wstrb, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    chk("t5_in_wait", dbg_state, 3'd3);
    chk("t5_drv_busy", flash_wbusy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    do_start(24'h100004, 32'h3100, 16'd1);
    chk("t5_held_off", flash_wstrb, 1'b0);
    wait_done(800);
    cycles(2);
    chk("t5_nflash", fl_log.size(), 5);
    chk("t5_nwr", wa_log.size(), 1);
    if (wa_log.size() == 1) begin
      chk("t5_wa", wa_log[0], 32'h3100);
      chk("t5_wd", wd_log[0], 32'h88776655);
    end
    flash_lat = 2;

    // Start while busy is ignored.
    clear_logs();
    do_start(24'h100000, 32'h4000, 16'd2);
    cycles(4);
    #1;
    chk("t6_busy", busy, 1'b1);
    do_start(24'h000000, 32'h9000, 16'd5);
    wait_done(800);
    cycles(5);
    chk("t6_nwr", wa_log.size(), 2);
    if (wa_log.size() == 2) begin
      chk("t6_wa1", wa_log[1], 32'h4004);
      chk("t6_wd1", wd_log[1], 32'h88776655);
    end

    // Start in the same cycle as done is ignored.
    clear_logs();
    do_start(24'h100004, 32'h5000, 16'd1);
    wait_done(500);
    start = 1'b1; src_addr = 24'h000000; dst_addr = 32'h6000; nwords = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles(5); #1;
    chk("t7_busy", busy, 1'b0);
    chk("t7_nwr", wa_log.size(), 1);
    chk("t7_nflash", fl_log.size(), 4);

    cycles(2);
    chk("end_queues", fl_exp_q.size() + wa_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 SHALL have parameter FLASH_AW, default 24, width of the flash byte address.
REQ-002 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle pulse that launches a copy; ignored while busy=1.
REQ-005 SHALL have port src_addr  in  FLASH_AW  first flash byte address, sampled on start.
REQ-006 SHALL have port dst_addr  in  32  first RAM byte address (word aligned), sampled on start.
REQ-007 SHALL have port nwords  in  16  number of 32-bit words to copy, sampled on start.
REQ-008 SHALL have port busy  out  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  out  1  one-cycle pulse when the copy completes.
REQ-010 SHALL have port checksum  out  32  running word sum (see Configuration).
REQ-011 SHALL have ports flash_sel and flash_wstrb  out  1 each  select and strobe to the SPI flash driver.
REQ-012 SHALL have port flash_wdata  out  32  {8'h00, flash byte address zero-extended to 24 bits}.
REQ-013 SHALL have port flash_wbusy  in  1  driver busy, read byte not yet valid.
REQ-014 SHALL have port flash_rdata  in  32  driver read data; only bits [7:0] used.
REQ-015 SHALL have ports mem_addr  out  32, mem_wdata  out  32, mem_wmask  out  4  RAM write address, data and byte mask.
REQ-016 SHALL have port mem_wstrb  out  1  RAM write request; mem_wbusy  in  1  RAM stall.

Function
REQ-017 SHALL implement states IDLE, ISSUE, ARM, WAIT, CAPTURE, WRITE, DONE.
REQ-018 IDLE: on start with nwords!=0, SHALL latch the inputs, clear the byte index and checksum, and go to ISSUE; with nwords==0, SHALL go to DONE with no flash or RAM access.
REQ-019 ISSUE: SHALL stay in ISSUE while flash_wbusy=1; otherwise SHALL assert flash_sel=flash_wstrb=1 for exactly one cycle with the current flash address, then go to ARM.
REQ-020 ARM: SHALL wait exactly one cycle, since the driver raises wbusy one cycle after its strobe, then go to WAIT.
REQ-021 WAIT: SHALL hold flash_sel=1 until flash_wbusy=0, then go to CAPTURE.
REQ-022 CAPTURE: with flash_sel=1, SHALL write flash_rdata[7:0] into word bits [8k+7:8k], where k is the byte index 0..3 (little-endian); SHALL increment the flash address and k; when k was 3, SHALL go to WRITE, else to ISSUE.
REQ-023 The flash address SHALL wrap modulo 2^FLASH_AW; mem_addr SHALL wrap modulo 2^32.
REQ-024 WRITE: SHALL drive mem_wstrb=1, mem_wmask=4'b1111 and stable mem_addr/mem_wdata, holding them while mem_wbusy=1.
REQ-025 The WRITE write SHALL be accepted in the first cycle with mem_wstrb=1 and mem_wbusy=0.
REQ-026 On WRITE acceptance, SHALL add 4 to mem_addr and decrement the word count; when the count reaches 0, SHALL go to DONE, else to ISSUE.
REQ-027 DONE: SHALL pulse done=1 for one cycle, drop busy in that same cycle, and return to IDLE.
REQ-028 flash_sel SHALL be 0 in IDLE, WRITE and DONE; mem_wstrb SHALL be 0 outside WRITE; mem_wmask SHALL be 0 outside WRITE.
REQ-029 A start arriving in the same cycle as done SHALL be ignored.

Reset
REQ-030 With reset=1, SHALL enter IDLE next cycle regardless of state, including mid-transfer.
REQ-031 Reset values: busy, done, flash_sel, flash_wstrb, mem_wstrb = 0; flash_wdata, mem_addr, mem_wdata, mem_wmask, checksum = 0.
REQ-032 After reset mid-transfer, the first ISSUE SHALL still wait for flash_wbusy=0 (REQ-019), so the driver's unfinished read completes first.

Configuration
REQ-033 With macro FLASH_LOADER_CHECKSUM_EN defined, checksum SHALL add each accepted word (mod 2^32), cleared on an accepted start.
REQ-034 With FLASH_LOADER_CHECKSUM_EN defined, checksum SHALL hold its value after done until the next start.
REQ-035 Without FLASH_LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no adder SHALL be synthesized.

Verification
REQ-036 Flash model bytes 11,22,33,44,55,66,77,88 at 0x100000; start with src=0x100000, dst=0x1000, nwords=2 -> RAM writes 0x44332211@0x1000 then 0x88776655@0x1004; done pulses once; checksum=0xCCAA8866 if CHECKSUM_EN.
REQ-037 nwords=0 -> done pulse within 2 cycles of start, no flash_wstrb or mem_wstrb ever asserted.
REQ-038 mem_wbusy held high 5 cycles during the first WRITE -> mem_addr/mem_wdata stable throughout; exactly one write per word accepted.
REQ-039 src=0xFFFFFE, nwords=1 -> flash addresses FFFFFE, FFFFFF, 000000, 000001 issued in order.
REQ-040 reset pulsed during WAIT with flash_wbusy=1 -> next cycle all outputs 0; a new start issues no flash_wstrb until flash_wbusy=0.
REQ-041 start pulsed while busy=1 -> ignored; the copy finishes with the original parameters.
